// File: rtl/prog_writer.sv
// ============================================================================
// Module      : prog_writer
// Description : Writable 2**ADDR_W x DATA_W program store with a streaming
//               valid/ready loader and a combinational fetch port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_writer #(
  parameter UUID       = 0,
  parameter NAME       = "",
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   wr_count,
  input  logic [DATA_W-1:0] Input,
  output logic [DATA_W-1:0] Output
);

  localparam int              c_depth   = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_max_len = c_depth[ADDR_W:0];
  localparam logic [ADDR_W:0] c_one     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_mem [c_depth];

  logic w_len_ok;
  logic w_xfer;
  logic w_unused;

  assign w_len_ok = (load_len != '0) && (load_len <= c_max_len);
  assign w_xfer   = (r_state == S_LOAD) && in_valid && in_ready;

  // Fetch sees the pre-edge array, so a same-cycle write is not forwarded.
  assign Output = r_mem[Input[ADDR_W-1:0]];

  // Upper fetch-address bits and the pass-through identifiers carry no logic.
  assign w_unused = ^{Input[DATA_W-1:ADDR_W], (UUID != 0), (NAME != "")};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wr_count    <= '0;
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            if (w_len_ok) begin
              r_addr      <= load_base;
              r_remaining <= load_len;
              wr_count    <= '0;
              in_ready    <= 1'b1;
              busy        <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_mem[r_addr] <= in_data;
            r_addr        <= r_addr + 1'b1;
            r_remaining   <= r_remaining - c_one;
            wr_count      <= wr_count + c_one;
            if (r_remaining == c_one) begin
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              r_state  <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_writer.sv
// ============================================================================
// Module      : tb_prog_writer
// Description : Directed self-checking bench for prog_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_start = 1'b0;
  logic [3:0] load_base = '0;
  logic [4:0] load_len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] wr_count;
  logic [7:0] Input = '0;
  logic [7:0] Output;

  int n_total = 0;
  int n_pass  = 0;

  prog_writer #(.UUID(0), .NAME(""), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .err(err),
    .wr_count(wr_count), .Input(Input), .Output(Output)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    Input = a;
    #1;
    check(tag, {24'd0, Output}, {24'd0, exp});
  endtask

  task automatic start(input logic [3:0] base, input logic [4:0] len);
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  logic [7:0] exp_mem [16];

  initial begin
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

    // 1: reset state and cleared memory
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wr_count", {27'd0, wr_count}, 32'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) rd(8'(i), 8'h00, "rst_mem");
    rd(8'hF3, 8'h00, "rst_mem_upper_bits");

    // 2: full 16-byte load, in_valid held high
    start(4'd0, 5'd16);
    check("t2_in_ready", {31'd0, in_ready}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_wr_count_clr", {27'd0, wr_count}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'h10 + 8'(i);
      exp_mem[i] = 8'h10 + 8'(i);
      tick();
      if (i < 15) check("t2_no_early_done", {31'd0, done}, 32'd0);
    end
    in_valid = 1'b0;
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_busy_fin", {31'd0, busy}, 32'd0);
    check("t2_ready_fin", {31'd0, in_ready}, 32'd0);
    check("t2_wr_count", {27'd0, wr_count}, 32'd16);
    tick();
    check("t2_done_pulse", {31'd0, done}, 32'd0);
    for (int i = 0; i < 16; i++) rd(8'(i), exp_mem[i], "t2_mem");

    // 3: wrap-around with a 3-cycle stall
    start(4'd14, 5'd4);
    Input = 8'd14;
    in_valid = 1'b1;
    in_data = 8'hA1;
    #1;
    check("t3_old_value_before_edge", {24'd0, Output}, 32'h1E);
    tick();
    check("t3_new_value_after_edge", {24'd0, Output}, 32'hA1);
    in_data = 8'hA2;
    tick();
    in_valid = 1'b0;
    in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_wr_count", {27'd0, wr_count}, 32'd2);
      check("t3_stall_busy", {31'd0, busy}, 32'd1);
    end
    in_valid = 1'b1;
    in_data = 8'hA3;
    tick();
    in_data = 8'hA4;
    tick();
    in_valid = 1'b0;
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_wr_count", {27'd0, wr_count}, 32'd4);
    exp_mem[14] = 8'hA1; exp_mem[15] = 8'hA2; exp_mem[0] = 8'hA3; exp_mem[1] = 8'hA4;
    tick();
    for (int i = 0; i < 16; i++) rd(8'(i), exp_mem[i], "t3_mem");

    // 4: illegal lengths
    start(4'd2, 5'd0);
    check("t4_err_len0", {31'd0, err}, 32'd1);
    check("t4_busy_len0", {31'd0, busy}, 32'd0);
    check("t4_ready_len0", {31'd0, in_ready}, 32'd0);
    tick();
    check("t4_err_pulse", {31'd0, err}, 32'd0);
    start(4'd2, 5'd17);
    check("t4_err_len17", {31'd0, err}, 32'd1);
    check("t4_busy_len17", {31'd0, busy}, 32'd0);
    tick();
    check("t4_err_pulse17", {31'd0, err}, 32'd0);
    check("t4_idle_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 16; i++) rd(8'(i), exp_mem[i], "t4_mem");

    // 5: second load_start mid-session is ignored
    start(4'd4, 5'd3);
    in_valid = 1'b1;
    in_data = 8'hB1;
    tick();
    in_valid = 1'b0;
    start(4'd8, 5'd2);
    check("t5_no_err", {31'd0, err}, 32'd0);
    check("t5_still_busy", {31'd0, busy}, 32'd1);
    check("t5_wr_count_kept", {27'd0, wr_count}, 32'd1);
    in_valid = 1'b1;
    in_data = 8'hB2;
    tick();
    in_data = 8'hB3;
    wait_done(4, "t5_done");
    in_valid = 1'b0;
    check("t5_wr_count", {27'd0, wr_count}, 32'd3);
    exp_mem[4] = 8'hB1; exp_mem[5] = 8'hB2; exp_mem[6] = 8'hB3;
    load_start = 1'b1;
    load_base = 4'd8;
    load_len = 5'd2;
    tick();
    load_start = 1'b0;
    check("t5_fin_ignores_start", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) rd(8'(i), exp_mem[i], "t5_mem");

    // 6: reset mid-load
    start(4'd3, 5'd5);
    in_valid = 1'b1;
    in_data = 8'hC1;
    tick();
    in_data = 8'hC2;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_ready", {31'd0, in_ready}, 32'd0);
    check("t6_wr_count", {27'd0, wr_count}, 32'd0);
    for (int i = 0; i < 16; i++) rd(8'(i), 8'h00, "t6_mem");
    tick();
    check("t6_no_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();
    start(4'd0, 5'd1);
    in_valid = 1'b1;
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    check("t6_new_done", {31'd0, done}, 32'd1);
    check("t6_new_wr_count", {27'd0, wr_count}, 32'd1);
    rd(8'd0, 8'h5A, "t6_new_mem0");
    rd(8'd3, 8'h00, "t6_new_mem3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
